// File: rtl/uart_rx_monitor.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
//  Module      : uart_rx_monitor
//  Description : UART receiver for 8-bit frames with optional even parity.
//                A 2-flop synchronizer feeds a start/data/parity/stop FSM.
//                Completed frames go to a one-entry holding register with a
//                valid/ready handshake, a sticky overrun flag and a
//                delivered-frame counter.
//  Revision    : 1.0 - initial release
// ============================================================================
module uart_rx_monitor #(
    parameter int BAUD_DIV  = 868,
    parameter int PARITY_EN = 1
) (
    input  logic        tb_clk,
    input  logic        tb_rst_n,
    input  logic        port_txd,
    output logic [7:0]  rx_data,
    output logic        rx_valid,
    input  logic        rx_ready,
    output logic        rx_perr,
    output logic        rx_ferr,
    output logic        ovr_err,
    input  logic        err_clr,
    output logic [15:0] frame_cnt
);

    // Counter reload values: half a bit to reach the start-bit centre,
    // then a full bit between successive sample points.
    localparam logic [15:0] C_HALF_CNT = 16'(BAUD_DIV / 2 - 1);
    localparam logic [15:0] C_FULL_CNT = 16'(BAUD_DIV - 1);

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_START  = 3'd1,
        S_DATA   = 3'd2,
        S_PARITY = 3'd3,
        S_STOP   = 3'd4
    } state_t;

    // Synchronizer and edge-detect flops
    logic        sync1_q, sync2_q, rxs_prev_q;
    // Frame decoder flops
    state_t      state_q, state_d;
    logic [15:0] cnt_q, cnt_d;
    logic [2:0]  bit_idx_q, bit_idx_d;
    logic [7:0]  shift_q, shift_d;
    logic        par_err_q, par_err_d;
    // Holding register flops
    logic [7:0]  rx_data_q, rx_data_d;
    logic        rx_valid_q, rx_valid_d;
    logic        rx_perr_q, rx_perr_d;
    logic        rx_ferr_q, rx_ferr_d;
    logic        ovr_err_q, ovr_err_d;
    logic [15:0] frame_cnt_q, frame_cnt_d;

    // Decoder-to-holding-register handoff
    logic        w_rxs;
    logic        w_cnt_zero;
    logic        w_frame_done;
    logic        w_done_ferr;
    logic        w_load;
    logic        w_overrun;

    assign w_rxs      = sync2_q;
    assign w_cnt_zero = (cnt_q == 16'd0);

    // Frame decoder: walks start/data/parity/stop, sampling at counter zero
    always_comb begin
        state_d      = state_q;
        cnt_d        = cnt_q;
        bit_idx_d    = bit_idx_q;
        shift_d      = shift_q;
        par_err_d    = par_err_q;
        w_frame_done = 1'b0;
        w_done_ferr  = 1'b0;
        case (state_q)
            S_IDLE: begin
                // Edge (not level) detection: a line stuck low after a
                // framing error cannot retrigger until it goes high again.
                if (rxs_prev_q && !w_rxs) begin
                    state_d = S_START;
                    cnt_d   = C_HALF_CNT;
                end
            end
            S_START: begin
                if (w_cnt_zero) begin
                    if (w_rxs) begin
                        state_d = S_IDLE;
                    end else begin
                        state_d   = S_DATA;
                        cnt_d     = C_FULL_CNT;
                        bit_idx_d = 3'd0;
                    end
                end else begin
                    cnt_d = cnt_q - 16'd1;
                end
            end
            S_DATA: begin
                if (w_cnt_zero) begin
                    shift_d = {w_rxs, shift_q[7:1]};
                    cnt_d   = C_FULL_CNT;
                    if (bit_idx_q == 3'd7) begin
                        par_err_d = 1'b0;
                        state_d   = (PARITY_EN != 0) ? S_PARITY : S_STOP;
                    end else begin
                        bit_idx_d = bit_idx_q + 3'd1;
                    end
                end else begin
                    cnt_d = cnt_q - 16'd1;
                end
            end
            S_PARITY: begin
                if (w_cnt_zero) begin
                    par_err_d = w_rxs ^ (^shift_q);
                    cnt_d     = C_FULL_CNT;
                    state_d   = S_STOP;
                end else begin
                    cnt_d = cnt_q - 16'd1;
                end
            end
            S_STOP: begin
                if (w_cnt_zero) begin
                    w_frame_done = 1'b1;
                    w_done_ferr  = ~w_rxs;
                    cnt_d        = 16'd0;
                    state_d      = S_IDLE;
                end else begin
                    cnt_d = cnt_q - 16'd1;
                end
            end
            default: begin
                state_d = S_IDLE;
                cnt_d   = 16'd0;
            end
        endcase
    end

    // Holding register: load when empty or being drained, otherwise overrun
    always_comb begin
        w_load      = w_frame_done & (~rx_valid_q | rx_ready);
        w_overrun   = w_frame_done & rx_valid_q & ~rx_ready;
        rx_data_d   = rx_data_q;
        rx_perr_d   = rx_perr_q;
        rx_ferr_d   = rx_ferr_q;
        rx_valid_d  = rx_valid_q;
        frame_cnt_d = frame_cnt_q;
        ovr_err_d   = ovr_err_q;
        if (w_load) begin
            rx_data_d   = shift_q;
            rx_perr_d   = (PARITY_EN != 0) ? par_err_q : 1'b0;
            rx_ferr_d   = w_done_ferr;
            rx_valid_d  = 1'b1;
            frame_cnt_d = frame_cnt_q + 16'd1;
        end else if (rx_valid_q && rx_ready) begin
            rx_valid_d = 1'b0;
        end
        // Overrun takes priority over a clear in the same cycle
        if (w_overrun) begin
            ovr_err_d = 1'b1;
        end else if (err_clr) begin
            ovr_err_d = 1'b0;
        end
    end

    // State registers; synchronizer resets to the idle-high line level
    always_ff @(posedge tb_clk or negedge tb_rst_n) begin
        if (!tb_rst_n) begin
            sync1_q     <= 1'b1;
            sync2_q     <= 1'b1;
            rxs_prev_q  <= 1'b1;
            state_q     <= S_IDLE;
            cnt_q       <= 16'd0;
            bit_idx_q   <= 3'd0;
            shift_q     <= 8'h00;
            par_err_q   <= 1'b0;
            rx_data_q   <= 8'h00;
            rx_valid_q  <= 1'b0;
            rx_perr_q   <= 1'b0;
            rx_ferr_q   <= 1'b0;
            ovr_err_q   <= 1'b0;
            frame_cnt_q <= 16'd0;
        end else begin
            sync1_q     <= port_txd;
            sync2_q     <= sync1_q;
            rxs_prev_q  <= sync2_q;
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            bit_idx_q   <= bit_idx_d;
            shift_q     <= shift_d;
            par_err_q   <= par_err_d;
            rx_data_q   <= rx_data_d;
            rx_valid_q  <= rx_valid_d;
            rx_perr_q   <= rx_perr_d;
            rx_ferr_q   <= rx_ferr_d;
            ovr_err_q   <= ovr_err_d;
            frame_cnt_q <= frame_cnt_d;
        end
    end

    assign rx_data   = rx_data_q;
    assign rx_valid  = rx_valid_q;
    assign rx_perr   = rx_perr_q;
    assign rx_ferr   = rx_ferr_q;
    assign ovr_err   = ovr_err_q;
    assign frame_cnt = frame_cnt_q;

endmodule
`default_nettype wire

// File: tb/tb_uart_rx_monitor.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
//  Module      : tb_uart_rx_monitor
//  Description : Self-checking bench for uart_rx_monitor. A queue of expected
//                frames is filled by the serial driver; one compare process
//                checks the holding register against it every cycle.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_uart_rx_monitor;

    localparam int  BAUD_DIV = 8;
    localparam real BIT_NS   = 80.5;   // slightly slow transmitter, 10 ns clock

    logic        tb_clk   = 1'b0;
    logic        tb_rst_n = 1'b0;
    logic        port_txd = 1'b1;
    logic        rx_ready = 1'b0;
    logic        err_clr  = 1'b0;
    logic [7:0]  rx_data;
    logic        rx_valid;
    logic        rx_perr;
    logic        rx_ferr;
    logic        ovr_err;
    logic [15:0] frame_cnt;

    int          total  = 0;
    int          bad    = 0;
    int          popped = 0;
    bit          done   = 1'b0;
    logic [9:0]  exp_q[$];           // {ferr, perr, data}
    logic [9:0]  last_pop = 10'h000;

    always #5 tb_clk = ~tb_clk;

    uart_rx_monitor #(
        .BAUD_DIV  (BAUD_DIV),
        .PARITY_EN (1)
    ) dut (
        .tb_clk    (tb_clk),
        .tb_rst_n  (tb_rst_n),
        .port_txd  (port_txd),
        .rx_data   (rx_data),
        .rx_valid  (rx_valid),
        .rx_ready  (rx_ready),
        .rx_perr   (rx_perr),
        .rx_ferr   (rx_ferr),
        .ovr_err   (ovr_err),
        .err_clr   (err_clr),
        .frame_cnt (frame_cnt)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Drive one frame; the expected outcome is queued from the frame content.
    task automatic send_frame(input logic [7:0] d, input logic par, input logic stop,
                              input bit expect_load);
        if (expect_load) exp_q.push_back({~stop, par ^ (^d), d});
        port_txd = 1'b0;
        #(BIT_NS);
        for (int i = 0; i < 8; i++) begin
            port_txd = d[i];
            #(BIT_NS);
        end
        port_txd = par;
        #(BIT_NS);
        port_txd = stop;
        #(BIT_NS);
        port_txd = 1'b1;
    endtask

    task automatic idle_bits(input int n);
        #(BIT_NS * n);
    endtask

    task automatic wait_empty(input string name);
        int n = 0;
        while (exp_q.size() != 0 && n < 64) begin
            @(negedge tb_clk);
            n++;
        end
        chk(name, exp_q.size(), 0);
    endtask

    task automatic set_ready(input logic v);
        @(posedge tb_clk);
        #1 rx_ready = v;
    endtask

    // Compare process: the held byte must be the oldest expected frame, and
    // frame_cnt must equal the number of frames delivered so far.
    task automatic monitor();
        logic [9:0] e;
        while (!done) begin
            @(negedge tb_clk);
            if (tb_rst_n) begin
                if (rx_valid) begin
                    if (exp_q.size() == 0) begin
                        chk("unexpected_valid", rx_valid, 0);
                    end else begin
                        e = exp_q[0];
                        chk("rx_data", rx_data, e[7:0]);
                        chk("rx_perr", rx_perr, e[8]);
                        chk("rx_ferr", rx_ferr, e[9]);
                        chk("frame_cnt_held", frame_cnt, popped + 1);
                        if (rx_ready) begin
                            void'(exp_q.pop_front());
                            popped++;
                            last_pop = e;
                        end
                    end
                end else begin
                    chk("frame_cnt_idle", frame_cnt, popped);
                end
            end
        end
    endtask

    task automatic stimulus();
        // Reset values
        #23;
        chk("rst_data", rx_data, 8'h00);
        chk("rst_valid", rx_valid, 0);
        chk("rst_perr", rx_perr, 0);
        chk("rst_ferr", rx_ferr, 0);
        chk("rst_ovr", ovr_err, 0);
        chk("rst_cnt", frame_cnt, 0);
        @(posedge tb_clk);
        #1 tb_rst_n = 1'b1;
        set_ready(1'b1);
        idle_bits(2);

        // Good frame
        send_frame(8'hA5, 1'b0, 1'b1, 1'b1);
        wait_empty("drain_a5");
        chk("a5_cnt", frame_cnt, 1);
        chk("a5_frame", last_pop, 10'h0A5);

        // Parity error
        send_frame(8'h3C, 1'b1, 1'b1, 1'b1);
        wait_empty("drain_3c");
        chk("3c_frame", last_pop, 10'h13C);

        // Framing error
        send_frame(8'h55, 1'b0, 1'b0, 1'b1);
        wait_empty("drain_55");
        chk("55_frame", last_pop, 10'h255);
        chk("55_cnt", frame_cnt, 3);
        idle_bits(2);

        // Break: line low for three frame times gives one all-zero frame
        exp_q.push_back(10'h200);
        port_txd = 1'b0;
        #(BIT_NS * 33);
        port_txd = 1'b1;
        idle_bits(4);
        wait_empty("drain_break");
        chk("break_frame", last_pop, 10'h200);
        chk("break_cnt", frame_cnt, 4);

        // Short glitch is rejected in the start state
        port_txd = 1'b0;
        #(BAUD_DIV / 4 * 10);
        port_txd = 1'b1;
        idle_bits(15);
        chk("glitch_cnt", frame_cnt, 4);
        chk("glitch_valid", rx_valid, 0);

        // Overrun: second byte dropped while the first is held
        set_ready(1'b0);
        send_frame(8'h11, 1'b0, 1'b1, 1'b1);
        idle_bits(1);
        send_frame(8'h22, 1'b0, 1'b1, 1'b0);
        idle_bits(2);
        chk("ovr_set", ovr_err, 1);
        chk("ovr_data", rx_data, 8'h11);
        chk("ovr_valid", rx_valid, 1);
        chk("ovr_cnt", frame_cnt, 5);
        @(posedge tb_clk);
        #1 err_clr = 1'b1;
        @(posedge tb_clk);
        #1 err_clr = 1'b0;
        chk("ovr_clr", ovr_err, 0);
        set_ready(1'b1);
        wait_empty("drain_11");
        chk("ovr_frame", last_pop, 10'h011);

        // Reset in the middle of a frame
        port_txd = 1'b0;
        #(BIT_NS * 3.3);
        tb_rst_n = 1'b0;
        #1;
        chk("mid_rst_data", rx_data, 8'h00);
        chk("mid_rst_valid", rx_valid, 0);
        chk("mid_rst_cnt", frame_cnt, 0);
        chk("mid_rst_ovr", ovr_err, 0);
        port_txd = 1'b1;
        exp_q.delete();
        popped = 0;
        #40;
        @(posedge tb_clk);
        #1 tb_rst_n = 1'b1;
        idle_bits(3);

        // Back-to-back loopback of every byte value
        for (int b = 0; b < 256; b++) begin
            logic [7:0] v;
            v = b[7:0];
            send_frame(v, ^v, 1'b1, 1'b1);
        end
        idle_bits(2);
        wait_empty("drain_loop");
        chk("loop_cnt", frame_cnt, 256);
        chk("loop_last", last_pop, 10'h0FF);
    endtask

    initial begin
        fork
            monitor();
            begin
                stimulus();
                done = 1'b1;
            end
        join
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire
